// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding for the execute stage.
// Drives the ALU operands, the forwarded store data and the destination tag to EX/MEM.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL_E,
    input  logic            FLUSH_E,
    input  logic            VALID_D,
    input  logic [3:0]      ALUOP_D,
    input  logic [RAW-1:0]  RA1_D,
    input  logic [RAW-1:0]  RA2_D,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [XLEN-1:0] IMM_D,
    input  logic            IMMSEL_D,
    input  logic [RAW-1:0]  WA_D,
    input  logic            REGWRITE_D,
    input  logic            REGWRITE_M,
    input  logic [RAW-1:0]  WA_M,
    input  logic [XLEN-1:0] ALUOUT_M,
    input  logic            REGWRITE_W,
    input  logic [RAW-1:0]  WA_W,
    input  logic [XLEN-1:0] RESULT_W,
    output logic [3:0]      ALUOP_E,
    output logic [XLEN-1:0] ALUSRC1,
    output logic [XLEN-1:0] ALUSRC2,
    output logic [XLEN-1:0] STOREDATA_E,
    output logic [RAW-1:0]  WA_E,
    output logic            REGWRITE_E,
    output logic            VALID_E
);

    logic            e_valid;
    logic [3:0]      e_aluop;
    logic [RAW-1:0]  e_ra1;
    logic [RAW-1:0]  e_ra2;
    logic [XLEN-1:0] e_opa;
    logic [XLEN-1:0] e_opb;
    logic [XLEN-1:0] e_imm;
    logic            e_immsel;
    logic [RAW-1:0]  e_wa;
    logic            e_regwrite;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    // MEM is the younger producer, so it wins over WB; r0 is an ordinary register here.
    always_comb begin
        fwd1 = e_opa;
        if (REGWRITE_M && (WA_M == e_ra1))
            fwd1 = ALUOUT_M;
        else if (REGWRITE_W && (WA_W == e_ra1))
            fwd1 = RESULT_W;

        fwd2 = e_opb;
        if (REGWRITE_M && (WA_M == e_ra2))
            fwd2 = ALUOUT_M;
        else if (REGWRITE_W && (WA_W == e_ra2))
            fwd2 = RESULT_W;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_valid    <= 1'b0;
            e_aluop    <= '0;
            e_ra1      <= '0;
            e_ra2      <= '0;
            e_opa      <= '0;
            e_opb      <= '0;
            e_imm      <= '0;
            e_immsel   <= 1'b0;
            e_wa       <= '0;
            e_regwrite <= 1'b0;
        end else if (FLUSH_E) begin
            e_valid    <= 1'b0;
            e_aluop    <= '0;
            e_ra1      <= '0;
            e_ra2      <= '0;
            e_opa      <= '0;
            e_opb      <= '0;
            e_imm      <= '0;
            e_immsel   <= 1'b0;
            e_wa       <= '0;
            e_regwrite <= 1'b0;
        end else if (STALL_E) begin
            // Keep control, but refresh operands so a value retiring from WB is not lost.
            e_opa <= fwd1;
            e_opb <= fwd2;
        end else begin
            e_valid    <= VALID_D;
            e_aluop    <= VALID_D ? ALUOP_D : 4'd0;
            e_ra1      <= RA1_D;
            e_ra2      <= RA2_D;
            e_opa      <= RD1_D;
            e_opb      <= RD2_D;
            e_imm      <= IMM_D;
            e_immsel   <= IMMSEL_D;
            e_wa       <= WA_D;
            e_regwrite <= VALID_D & REGWRITE_D;
        end
    end

    assign ALUSRC1     = fwd1;
    assign ALUSRC2     = e_immsel ? e_imm : fwd2;
    assign STOREDATA_E = fwd2;
    assign ALUOP_E     = e_aluop;
    assign WA_E        = e_wa;
    assign REGWRITE_E  = e_regwrite & e_valid;
    assign VALID_E     = e_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, immediate select,
// stall capture, flush-over-stall, invalid-slot forcing, r0 forwarding, async reset.
module tb_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL_E, FLUSH_E, VALID_D, IMMSEL_D, REGWRITE_D;
  logic [3:0]  ALUOP_D;
  logic [4:0]  RA1_D, RA2_D, WA_D, WA_M, WA_W;
  logic [31:0] RD1_D, RD2_D, IMM_D, ALUOUT_M, RESULT_W;
  logic        REGWRITE_M, REGWRITE_W;
  logic [3:0]  ALUOP_E;
  logic [31:0] ALUSRC1, ALUSRC2, STOREDATA_E;
  logic [4:0]  WA_E;
  logic        REGWRITE_E, VALID_E;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.XLEN(32), .RAW(5)) dut (
    .CLK(CLK), .RST(RST), .STALL_E(STALL_E), .FLUSH_E(FLUSH_E),
    .VALID_D(VALID_D), .ALUOP_D(ALUOP_D), .RA1_D(RA1_D), .RA2_D(RA2_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .IMM_D(IMM_D), .IMMSEL_D(IMMSEL_D),
    .WA_D(WA_D), .REGWRITE_D(REGWRITE_D),
    .REGWRITE_M(REGWRITE_M), .WA_M(WA_M), .ALUOUT_M(ALUOUT_M),
    .REGWRITE_W(REGWRITE_W), .WA_W(WA_W), .RESULT_W(RESULT_W),
    .ALUOP_E(ALUOP_E), .ALUSRC1(ALUSRC1), .ALUSRC2(ALUSRC2),
    .STOREDATA_E(STOREDATA_E), .WA_E(WA_E), .REGWRITE_E(REGWRITE_E),
    .VALID_E(VALID_E)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_d(input logic v, input logic [3:0] op, input logic [4:0] ra1,
                        input logic [4:0] ra2, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic isel, input logic [4:0] wa,
                        input logic rw);
    VALID_D = v; ALUOP_D = op; RA1_D = ra1; RA2_D = ra2; RD1_D = rd1; RD2_D = rd2;
    IMM_D = imm; IMMSEL_D = isel; WA_D = wa; REGWRITE_D = rw;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; STALL_E = 0; FLUSH_E = 0;
    REGWRITE_M = 0; WA_M = 0; ALUOUT_M = 0;
    REGWRITE_W = 0; WA_W = 0; RESULT_W = 0;
    load_d(1, 4'd5, 5'd3, 5'd4, 32'h1234, 32'h22, 32'h100, 0, 5'd7, 1);

    // Reset holds everything at 0 across clock edges
    tick(); tick();
    check("rst_alusrc1", ALUSRC1, 32'h0);
    check("rst_alusrc2", ALUSRC2, 32'h0);
    check("rst_store", STOREDATA_E, 32'h0);
    check("rst_aluop", {28'h0, ALUOP_E}, 32'h0);
    check("rst_wa", {27'h0, WA_E}, 32'h0);
    check("rst_regwrite", {31'h0, REGWRITE_E}, 32'h0);
    check("rst_valid", {31'h0, VALID_E}, 32'h0);

    // Release reset: first edge loads D
    RST = 1'b0;
    RD1_D = 32'h11;
    tick();
    check("load_valid", {31'h0, VALID_E}, 32'h1);
    check("load_aluop", {28'h0, ALUOP_E}, 32'h5);
    check("load_wa", {27'h0, WA_E}, 32'h7);
    check("load_regwrite", {31'h0, REGWRITE_E}, 32'h1);
    check("load_alusrc1", ALUSRC1, 32'h11);
    check("load_alusrc2", ALUSRC2, 32'h22);
    check("load_store", STOREDATA_E, 32'h22);

    // Forward priority within one cycle (no edge in between)
    REGWRITE_M = 1; WA_M = 5'd3; ALUOUT_M = 32'hAA;
    REGWRITE_W = 1; WA_W = 5'd3; RESULT_W = 32'hBB;
    #1;
    check("fwd_mem", ALUSRC1, 32'hAA);
    check("fwd_src2_untouched", ALUSRC2, 32'h22);
    REGWRITE_M = 0;
    #1;
    check("fwd_wb", ALUSRC1, 32'hBB);
    REGWRITE_W = 0;
    #1;
    check("fwd_none", ALUSRC1, 32'h11);

    // Immediate select while RA2 is forwarded from MEM
    load_d(1, 4'd2, 5'd1, 5'd6, 32'h5, 32'h66, 32'hFFFF_FFF0, 1, 5'd8, 1);
    tick();
    REGWRITE_M = 1; WA_M = 5'd6; ALUOUT_M = 32'h55;
    #1;
    check("imm_alusrc2", ALUSRC2, 32'hFFFF_FFF0);
    check("imm_store_fwd", STOREDATA_E, 32'h55);
    check("imm_alusrc1", ALUSRC1, 32'h5);
    REGWRITE_M = 0;

    // Stall capture: WB value appears in cycle 1 only, must persist in cycle 2
    load_d(1, 4'd3, 5'd2, 5'd9, 32'h20, 32'h99, 32'h0, 0, 5'd10, 1);
    tick();
    check("stall_pre", ALUSRC2, 32'h99);
    STALL_E = 1;
    REGWRITE_W = 1; WA_W = 5'd9; RESULT_W = 32'h77;
    load_d(1, 4'd12, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1, 1, 5'd1, 0);
    #1;
    check("stall_c1_fwd", ALUSRC2, 32'h77);
    tick();
    REGWRITE_W = 0; RESULT_W = 32'h0;
    #1;
    check("stall_c2_held", ALUSRC2, 32'h77);
    check("stall_c2_store", STOREDATA_E, 32'h77);
    check("stall_c2_aluop", {28'h0, ALUOP_E}, 32'h3);
    check("stall_c2_wa", {27'h0, WA_E}, 32'hA);
    check("stall_c2_src1", ALUSRC1, 32'h20);
    tick();
    check("stall_c3_held", ALUSRC2, 32'h77);

    // Flush wins over stall
    FLUSH_E = 1;
    tick();
    check("flush_valid", {31'h0, VALID_E}, 32'h0);
    check("flush_regwrite", {31'h0, REGWRITE_E}, 32'h0);
    check("flush_aluop", {28'h0, ALUOP_E}, 32'h0);
    check("flush_wa", {27'h0, WA_E}, 32'h0);
    check("flush_alusrc2", ALUSRC2, 32'h0);
    FLUSH_E = 0; STALL_E = 0;

    // Invalid slot forces REGWRITE and ALUOP to 0
    load_d(0, 4'd1, 5'd2, 5'd3, 32'h44, 32'h45, 32'h0, 0, 5'd5, 1);
    tick();
    check("inv_regwrite", {31'h0, REGWRITE_E}, 32'h0);
    check("inv_aluop", {28'h0, ALUOP_E}, 32'h0);
    check("inv_valid", {31'h0, VALID_E}, 32'h0);
    check("inv_wa", {27'h0, WA_E}, 32'h5);

    // r0 forwards like any other register
    load_d(1, 4'd4, 5'd0, 5'd0, 32'h3, 32'h4, 32'h0, 0, 5'd11, 1);
    tick();
    REGWRITE_M = 1; WA_M = 5'd0; ALUOUT_M = 32'hCAFE;
    #1;
    check("r0_fwd_src1", ALUSRC1, 32'hCAFE);
    check("r0_fwd_store", STOREDATA_E, 32'hCAFE);
    REGWRITE_M = 0;
    #1;
    check("r0_pre_rst_valid", {31'h0, VALID_E}, 32'h1);

    // Asynchronous reset mid-cycle, during a stall
    STALL_E = 1;
    RST = 1'b1;
    #1;
    check("arst_valid", {31'h0, VALID_E}, 32'h0);
    check("arst_aluop", {28'h0, ALUOP_E}, 32'h0);
    check("arst_alusrc1", ALUSRC1, 32'h0);
    check("arst_wa", {27'h0, WA_E}, 32'h0);
    STALL_E = 0;
    RST = 1'b0;
    tick();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
